// File: rtl/twiddle_gen_pipe.sv
// twiddle_gen_pipe
//   Pipelined twiddle-factor generator for the first stage of a radix-2^LOGR
//   FFT. It walks one frame of ROWS*COLS factors W_N^(row*col) in row-major
//   order, reading a quarter-wave Q1.15 cosine table (N/4+1 entries) that is
//   built at elaboration time. Issue-to-output latency is two cycles.
//
//   Parameters: LOGN (log2 FFT size, 4..10), LOGR (log2 column count,
//   1..LOGN-1), NW (output width, 8..16).
//   Optional build macro: TWGEN_ROUND_EN -- round half-up with positive
//   saturation when narrowing to NW < 16 bits; without it the low bits are
//   simply dropped.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   frame start / restart pulse (wins over adv)
//     adv    in   issue the next factor this cycle (ignored when idle)
//     ifft   in   0: W=exp(-j*th), 1: W=exp(+j*th); sampled with start
//     wr     out  real part of W, signed NW bits
//     wi     out  imaginary part of W, signed NW bits
//     valid  out  wr/wi hold a factor
//     last   out  factor is the last of its frame (qualified by valid)
//     busy   out  frame in progress
module twiddle_gen_pipe #(
  parameter int LOGN = 6,
  parameter int LOGR = 3,
  parameter int NW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 adv,
  input  logic                 ifft,
  output logic signed [NW-1:0] wr,
  output logic signed [NW-1:0] wi,
  output logic                 valid,
  output logic                 last,
  output logic                 busy
);

  localparam int N   = 1 << LOGN;
  localparam int QN  = N / 4;
  localparam int RW  = LOGN - LOGR;
  localparam int CW  = LOGR;
  localparam int MW  = LOGN - 2;
  localparam int RSH = (NW < 16) ? (15 - NW) : 0;
  localparam logic [16:0] RND = (NW < 16) ? (17'd1 << RSH) : 17'd0;

  // round(32767*cos(2*pi*k/N)) with 64-bit fixed-point (Q30) Taylor series,
  // so the table needs no real arithmetic at elaboration.
  function automatic logic [15:0] cos_q15(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint c;
    x    = (64'sd3373259426 * longint'(2 * k)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int i = 1; i <= 10; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    c = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    if (k == 0) begin
      c = 64'sd32767;
    end else if (k == QN || c < 64'sd0) begin
      c = 64'sd0;
    end else begin
      c = c;
    end
    return c[15:0];
  endfunction

  function automatic logic [16*(QN+1)-1:0] build_tab();
    logic [16*(QN+1)-1:0] t;
    t = '0;
    for (int k = 0; k <= QN; k++) begin
      t[16*k +: 16] = cos_q15(k);
    end
    return t;
  endfunction

  localparam logic [16*(QN+1)-1:0] COS_TAB = build_tab();

`ifdef TWGEN_ROUND_EN
  // Round half-up to NW bits; only a positive value can overflow.
  function automatic logic signed [NW-1:0] narrow(input logic signed [15:0] v);
    logic [16:0] s;
    s = {v[15], v} + RND;
    if (!s[16] && s[15]) begin
      return {1'b0, {(NW-1){1'b1}}};
    end else begin
      return s[15 -: NW];
    end
  endfunction
`else
  // Plain truncation to the top NW bits.
  function automatic logic signed [NW-1:0] narrow(input logic signed [15:0] v);
    return v[15 -: NW];
  endfunction
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r;
  logic [RW-1:0]     row_r;
  logic [CW-1:0]     col_r;
  logic [LOGN-1:0]   e_r;
  logic              mode_r;
  logic              busy_r;
  logic              issue_s;
  logic              final_s;
  logic [MW-1:0]     m_s;

  logic              s1_valid_r;
  logic              s1_last_r;
  logic              s1_mode_r;
  logic [1:0]        s1_q_r;
  logic signed [15:0] s1_a_r;
  logic signed [15:0] s1_b_r;

  logic signed [15:0] cos_s;
  logic signed [15:0] sin_s;
  logic signed [15:0] wi16_s;

  // start blocks issue in the same cycle; the final element has all-ones counters.
  assign issue_s = (state_r == RUN) && adv && !start;
  assign final_s = (&row_r) && (&col_r);
  assign m_s     = e_r[MW-1:0];
  assign busy    = busy_r;

  // Frame FSM: row/column walk with incremental exponent e = row*col mod N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      row_r   <= '0;
      col_r   <= '0;
      e_r     <= '0;
      mode_r  <= 1'b0;
    end else if (start) begin
      state_r <= RUN;
      busy_r  <= 1'b1;
      row_r   <= '0;
      col_r   <= '0;
      e_r     <= '0;
      mode_r  <= ifft;
    end else if (issue_s) begin
      if (final_s) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
        row_r   <= '0;
        col_r   <= '0;
        e_r     <= '0;
      end else if (!(&col_r)) begin
        col_r <= col_r + CW'(1);
        e_r   <= e_r + LOGN'(row_r);
      end else begin
        col_r <= '0;
        row_r <= row_r + RW'(1);
        e_r   <= '0;
      end
    end
  end

  // Stage 1: quadrant split and the two table reads C[m], C[N/4-m].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_mode_r  <= 1'b0;
      s1_q_r     <= 2'd0;
      s1_a_r     <= 16'sd0;
      s1_b_r     <= 16'sd0;
    end else begin
      s1_valid_r <= issue_s;
      s1_last_r  <= issue_s && final_s;
      s1_mode_r  <= mode_r;
      s1_q_r     <= e_r[LOGN-1 -: 2];
      s1_a_r     <= COS_TAB[16*int'(m_s) +: 16];
      s1_b_r     <= COS_TAB[16*(QN - int'(m_s)) +: 16];
    end
  end

  // Quadrant reconstruction of cos/sin and the mode-dependent sign of WI.
  always_comb begin
    cos_s  = s1_a_r;
    sin_s  = s1_b_r;
    wi16_s = 16'sd0;
    case (s1_q_r)
      2'd0: begin cos_s = s1_a_r;  sin_s = s1_b_r;  end
      2'd1: begin cos_s = -s1_b_r; sin_s = s1_a_r;  end
      2'd2: begin cos_s = -s1_a_r; sin_s = -s1_b_r; end
      2'd3: begin cos_s = s1_b_r;  sin_s = -s1_a_r; end
      default: begin cos_s = s1_a_r; sin_s = s1_b_r; end
    endcase
    if (s1_mode_r) begin
      wi16_s = sin_s;
    end else begin
      wi16_s = -sin_s;
    end
  end

  // Stage 2: registered, narrowed outputs with their valid/last tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      last  <= 1'b0;
      wr    <= '0;
      wi    <= '0;
    end else begin
      valid <= s1_valid_r;
      last  <= s1_last_r;
      wr    <= narrow(cos_s);
      wi    <= narrow(wi16_s);
    end
  end

endmodule

// File: tb/tb_twiddle_gen_pipe.sv
// tb_twiddle_gen_pipe
//   Drives three generator instances from one stimulus stream:
//     dut0: defaults (LOGN=6, LOGR=3, NW=16)
//     dut1: NW=12 (rounding follows TWGEN_ROUND_EN when defined)
//     dut2: LOGN=8, LOGR=4
//   A reference model computes each frame position as idx -> (idx/COLS,
//   idx%COLS) -> e=row*col mod N and the factor from real cos/sin.
module tb_twiddle_gen_pipe;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst_n;
  logic start;
  logic adv;
  logic ifft;

  logic signed [15:0] wr0, wi0;
  logic signed [11:0] wr1, wi1;
  logic signed [15:0] wr2, wi2;
  logic valid0, last0, busy0;
  logic valid1, last1, busy1;
  logic valid2, last2, busy2;

  int n_checks = 0;
  int n_errors = 0;

  twiddle_gen_pipe #(.LOGN(6), .LOGR(3), .NW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .adv(adv), .ifft(ifft),
    .wr(wr0), .wi(wi0), .valid(valid0), .last(last0), .busy(busy0));
  twiddle_gen_pipe #(.LOGN(6), .LOGR(3), .NW(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .adv(adv), .ifft(ifft),
    .wr(wr1), .wi(wi1), .valid(valid1), .last(last1), .busy(busy1));
  twiddle_gen_pipe #(.LOGN(8), .LOGR(4), .NW(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .adv(adv), .ifft(ifft),
    .wr(wr2), .wi(wi2), .valid(valid2), .last(last2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic int narrow_ref(input int v, input int nw);
    int r;
    int mx;
    if (nw == 16) return v;
    mx = (1 << (nw - 1)) - 1;
`ifdef TWGEN_ROUND_EN
    r = (v + (1 << (15 - nw))) >>> (16 - nw);
    if (r > mx) r = mx;
`else
    r = v >>> (16 - nw);
`endif
    return r;
  endfunction

  task automatic ref_val(input int logn, input int nw, input int e, input int md,
                         output int owr, output int owi);
    real th;
    int c;
    int s;
    th  = 2.0 * PI * e / (2.0 ** logn);
    c   = rnd(32767.0 * $cos(th));
    s   = rnd(32767.0 * $sin(th));
    owr = narrow_ref(c, nw);
    owi = narrow_ref(md ? s : -s, nw);
  endtask

  // Per-instance configuration
  int cfg_logn [3] = '{6, 6, 8};
  int cfg_logr [3] = '{3, 3, 4};
  int cfg_nw   [3] = '{16, 12, 16};

  // Model state: frame position and a two-deep expected pipeline
  int m_busy [3];
  int m_idx  [3];
  int m_mode [3];
  int p1_v [3], p1_l [3], p1_wr [3], p1_wi [3];
  int p2_v [3], p2_l [3], p2_wr [3], p2_wi [3];

  always @(posedge clk or negedge rst_n) begin : model
    int e, total, cols, owr, owi;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 0; m_idx[k] <= 0; m_mode[k] <= 0;
        p1_v[k] <= 0; p1_l[k] <= 0; p1_wr[k] <= 0; p1_wi[k] <= 0;
        p2_v[k] <= 0; p2_l[k] <= 0; p2_wr[k] <= 0; p2_wi[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        p2_v[k] <= p1_v[k]; p2_l[k] <= p1_l[k];
        p2_wr[k] <= p1_wr[k]; p2_wi[k] <= p1_wi[k];
        total = 1 << cfg_logn[k];
        cols  = 1 << cfg_logr[k];
        if (start) begin
          m_busy[k] <= 1; m_idx[k] <= 0; m_mode[k] <= int'(ifft);
          p1_v[k] <= 0; p1_l[k] <= 0;
        end else if (m_busy[k] != 0 && adv) begin
          e = ((m_idx[k] / cols) * (m_idx[k] % cols)) % total;
          ref_val(cfg_logn[k], cfg_nw[k], e, m_mode[k], owr, owi);
          p1_v[k] <= 1; p1_wr[k] <= owr; p1_wi[k] <= owi;
          p1_l[k] <= (m_idx[k] == total - 1) ? 1 : 0;
          m_idx[k] <= m_idx[k] + 1;
          if (m_idx[k] == total - 1) m_busy[k] <= 0;
        end else begin
          p1_v[k] <= 0; p1_l[k] <= 0;
        end
      end
    end
  end

  // Captured outputs for spot checks of specific frame positions
  int cw0[$], ci0[$], cw1[$], cw2[$], ci2[$];

  always @(negedge clk) begin : checker_blk
    int o_wr [3], o_wi [3], o_v [3], o_l [3], o_b [3];
    o_wr[0] = wr0; o_wi[0] = wi0; o_v[0] = valid0; o_l[0] = last0; o_b[0] = busy0;
    o_wr[1] = wr1; o_wi[1] = wi1; o_v[1] = valid1; o_l[1] = last1; o_b[1] = busy1;
    o_wr[2] = wr2; o_wi[2] = wi2; o_v[2] = valid2; o_l[2] = last2; o_b[2] = busy2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), o_v[k], p2_v[k]);
      chk($sformatf("last%0d", k), o_l[k], p2_l[k]);
      chk($sformatf("busy%0d", k), o_b[k], m_busy[k]);
      if (p2_v[k] != 0) begin
        chk($sformatf("wr%0d", k), o_wr[k], p2_wr[k]);
        chk($sformatf("wi%0d", k), o_wi[k], p2_wi[k]);
      end
    end
    if (valid0) begin cw0.push_back(int'(wr0)); ci0.push_back(int'(wi0)); end
    if (valid1) cw1.push_back(int'(wr1));
    if (valid2) begin cw2.push_back(int'(wr2)); ci2.push_back(int'(wi2)); end
  end

  task automatic drive(input logic s, input logic a, input logic i);
    @(negedge clk);
    #1;
    start = s;
    adv   = a;
    ifft  = i;
  endtask

  task automatic clear_caps();
    cw0.delete(); ci0.delete(); cw1.delete(); cw2.delete(); ci2.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr0"}, int'(wr0), 0);
    chk({tag, "_wi0"}, int'(wi0), 0);
    chk({tag, "_wr1"}, int'(wr1), 0);
    chk({tag, "_wr2"}, int'(wr2), 0);
    chk({tag, "_v"}, int'(valid0 | valid1 | valid2), 0);
    chk({tag, "_l"}, int'(last0 | last1 | last2), 0);
    chk({tag, "_b"}, int'(busy0 | busy1 | busy2), 0);
  endtask

  initial begin
    int ewr, ewi, d;
    int pat [5] = '{1, 0, 1, 1, 0};
    rst_n = 1'b0; start = 1'b0; adv = 1'b0; ifft = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Full FFT frames; ifft toggled mid-frame must not matter
    clear_caps();
    drive(1'b1, 1'b0, 1'b0);
    repeat (260) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("t1_count0", cw0.size(), 64);
    chk("t1_count2", cw2.size(), 256);
    chk("t1_idx0_wr", cw0[0], 32'h7FFF);
    chk("t1_idx0_wi", ci0[0], 0);
    chk("t1_idx8_wr", cw0[8], 32'h7FFF);
    chk("t1_idx20_wr", cw0[20], 32'h5A82);
    chk("t1_idx20_wi", ci0[20], -23170);
    chk("t1_idx63_wr", cw0[63], 32'h0C8C);
    chk("t5_idx1_wr12", cw1[1], 32'h7FF);
    ref_val(8, 16, 15, 0, ewr, ewi);
    d = cw2[53] - ewr;
    chk("t6_e15_wr_1lsb", int'(d >= -1 && d <= 1), 1);
    d = ci2[53] - ewi;
    chk("t6_e15_wi_1lsb", int'(d >= -1 && d <= 1), 1);

    // IFFT frame
    clear_caps();
    drive(1'b1, 1'b0, 1'b1);
    repeat (66) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("t2_count0", cw0.size(), 64);
    chk("t2_idx9_wi", ci0[9], 32'h0C8C);
    chk("t2_idx63_wr", cw0[63], 32'h0C8C);

    // ADV bubble pattern
    drive(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 5; j++) drive(1'b0, 1'(pat[j]), 1'b0);

    // Restart mid-frame, with start and adv together
    drive(1'b1, 1'b0, 1'b0);
    repeat (30) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    repeat (70) drive(1'b0, 1'b1, 1'b0);

    // Randomized traffic
    repeat (900) drive(1'($urandom_range(0, 49) == 0),
                       1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)));

    // Asynchronous reset mid-frame
    drive(1'b1, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) drive(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
